// File: rtl/interrupt_pending_ctrl.sv
// Eight-source interrupt pending/offer controller: captures requests into a pending
// vector, offers the highest unmasked source, and tracks acknowledge/end-of-interrupt.
//
// state   | meaning
// IDLE    | no offer outstanding, waiting for a non-empty selection
// OFFER   | irq_valid high, irq_id frozen until irq_ack
// SERVICE | offer accepted, busy high until eoi
module interrupt_pending_ctrl #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic [7:0] mask,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;

  state_t     state;
  logic [7:0] prev;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic       sel_valid;
  logic [2:0] sel_id;

  always_comb begin
    set_vec = EDGE ? (req_in & ~prev) : req_in;
  end

  // Ascending scan so the last hit is the highest unmasked index.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (pending[k] && !mask[k]) begin
        sel_valid = 1'b1;
        sel_id    = 3'(k);
      end
    end
  end

  always_comb begin
    clr_vec = 8'h00;
    if (state == OFFER && irq_ack) clr_vec[irq_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= 8'h00;
      pending   <= 8'h00;
      irq_valid <= 1'b0;
      irq_id    <= 3'd0;
      busy      <= 1'b0;
    end else begin
      prev    <= req_in;
      // A set on the same edge as the ack clear wins.
      pending <= (pending & ~clr_vec) | set_vec;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state     <= OFFER;
            irq_id    <= sel_id;
            irq_valid <= 1'b1;
          end
        end
        OFFER: begin
          if (irq_ack) begin
            state     <= SERVICE;
            irq_valid <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_pending_ctrl.sv
// Bench for interrupt_pending_ctrl: edge- and level-mode instances share stimulus and
// are compared every cycle against a behavioural model plus directed scenario checks.
module tb_interrupt_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_in = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       irq_ack = 1'b0;
  logic       eoi = 1'b0;

  logic       irq_valid [2];
  logic [2:0] irq_id [2];
  logic [7:0] pending [2];
  logic       busy [2];

  int checks = 0;
  int errors = 0;

  // model: index 0 = edge capture, 1 = level capture; st 0 idle, 1 offer, 2 service
  int         m_st [2];
  logic [7:0] m_pend [2];
  logic [7:0] m_prev [2];
  logic [2:0] m_id [2];

  always #5 clk = ~clk;

  interrupt_pending_ctrl #(.EDGE(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .irq_ack(irq_ack), .eoi(eoi),
    .irq_valid(irq_valid[0]), .irq_id(irq_id[0]), .pending(pending[0]), .busy(busy[0])
  );

  interrupt_pending_ctrl #(.EDGE(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .irq_ack(irq_ack), .eoi(eoi),
    .irq_valid(irq_valid[1]), .irq_id(irq_id[1]), .pending(pending[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m] = 0; m_pend[m] = 8'h00; m_prev[m] = 8'h00; m_id[m] = 3'd0;
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] mk, input logic a, input logic e);
    for (int m = 0; m < 2; m++) begin
      logic [7:0] setv;
      logic [7:0] clr;
      int sel;
      setv = (m == 0) ? (r & ~m_prev[m]) : r;
      clr  = 8'h00;
      if (m_st[m] == 0) begin
        sel = -1;
        for (int k = 7; k >= 0; k--)
          if (sel < 0 && m_pend[m][k] && !mk[k]) sel = k;
        if (sel >= 0) begin
          m_st[m] = 1;
          m_id[m] = 3'(sel);
        end
      end else if (m_st[m] == 1) begin
        if (a) begin
          clr[m_id[m]] = 1'b1;
          m_st[m] = 2;
        end
      end else if (e) begin
        m_st[m] = 0;
      end
      m_pend[m] = (m_pend[m] & ~clr) | setv;
      m_prev[m] = r;
    end
  endtask

  task automatic compare_model();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_valid", m), 32'(irq_valid[m]), 32'(m_st[m] == 1));
      check($sformatf("m%0d_busy", m), 32'(busy[m]), 32'(m_st[m] == 2));
      check($sformatf("m%0d_pend", m), 32'(pending[m]), 32'(m_pend[m]));
      if (m_st[m] == 1) check($sformatf("m%0d_id", m), 32'(irq_id[m]), 32'(m_id[m]));
    end
  endtask

  // Apply inputs for one clock, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic [7:0] r, input logic [7:0] mk, input logic a, input logic e);
    req_in = r; mask = mk; irq_ack = a; eoi = e;
    @(posedge clk);
    model_step(r, mk, a, e);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    req_in = 8'h00; mask = 8'h00; irq_ack = 1'b0; eoi = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      check("rst_valid", 32'(irq_valid[m]), 32'd0);
      check("rst_id", 32'(irq_id[m]), 32'd0);
      check("rst_pend", 32'(pending[m]), 32'd0);
      check("rst_busy", 32'(busy[m]), 32'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] ids;
    logic [7:0] rr;
    logic [7:0] mm;
    logic [23:0] order;
    logic [23:0] after;

    do_reset();

    // single request, edge instance
    cycle(8'h04, 8'h00, 1'b0, 1'b0);
    check("s_pend", 32'(pending[0]), 32'h04);
    check("s_novalid", 32'(irq_valid[0]), 32'd0);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    check("s_valid", 32'(irq_valid[0]), 32'd1);
    check("s_id", 32'(irq_id[0]), 32'd2);
    cycle(8'h00, 8'h00, 1'b1, 1'b0);
    check("s_ackpend", 32'(pending[0]), 32'h00);
    check("s_busy", 32'(busy[0]), 32'd1);
    cycle(8'h00, 8'h00, 1'b0, 1'b1);
    check("s_eoi", 32'(busy[0]), 32'd0);

    // priority order 7, 2, 0
    order = {8'd0, 8'd2, 8'd7};
    after = {8'h00, 8'h01, 8'h05};
    cycle(8'h85, 8'h00, 1'b0, 1'b0);
    check("p_pend", 32'(pending[0]), 32'h85);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 8'h00, 1'b0, 1'b0);
      ids = order[8*i +: 8];
      check("p_id", 32'(irq_id[0]), 32'(ids));
      cycle(8'h00, 8'h00, 1'b1, 1'b0);
      ids = after[8*i +: 8];
      check("p_pend_after", 32'(pending[0]), 32'(ids));
      cycle(8'h00, 8'h00, 1'b0, 1'b1);
    end

    // masking
    do_reset();
    cycle(8'hC0, 8'h80, 1'b0, 1'b0);
    cycle(8'h00, 8'h80, 1'b0, 1'b0);
    check("mk_id6", 32'(irq_id[0]), 32'd6);
    cycle(8'h00, 8'h80, 1'b1, 1'b0);
    check("mk_pend7", 32'(pending[0]), 32'h80);
    cycle(8'h00, 8'h00, 1'b0, 1'b1);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    check("mk_id7", 32'(irq_id[0]), 32'd7);
    check("mk_valid7", 32'(irq_valid[0]), 32'd1);

    // no preemption
    do_reset();
    cycle(8'h02, 8'h00, 1'b0, 1'b0);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    cycle(8'h20, 8'h00, 1'b0, 1'b0);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    check("np_hold", 32'(irq_id[0]), 32'd1);
    cycle(8'h00, 8'h00, 1'b1, 1'b0);
    cycle(8'h00, 8'h00, 1'b0, 1'b1);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    check("np_next", 32'(irq_id[0]), 32'd5);

    // set/clear collision on bit 3
    do_reset();
    cycle(8'h08, 8'h00, 1'b0, 1'b0);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    cycle(8'h08, 8'h00, 1'b1, 1'b0);
    check("col_pend", 32'(pending[0]), 32'h08);
    check("col_busy", 32'(busy[0]), 32'd1);
    cycle(8'h00, 8'h00, 1'b0, 1'b1);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    check("col_reoffer", 32'(irq_id[0]), 32'd3);
    check("col_revalid", 32'(irq_valid[0]), 32'd1);

    // async reset during service with pending 0x12
    do_reset();
    cycle(8'h12, 8'h00, 1'b0, 1'b0);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    cycle(8'h10, 8'h00, 1'b1, 1'b0);
    check("ar_pend", 32'(pending[0]), 32'h12);
    check("ar_busy", 32'(busy[0]), 32'd1);
    do_reset();

    // level mode with request held high: id 2 re-offered after every eoi
    for (int i = 0; i < 3; i++) begin
      cycle(8'h04, 8'h00, 1'b0, 1'b0);
      cycle(8'h04, 8'h00, 1'b0, 1'b0);
      check("lv_valid", 32'(irq_valid[1]), 32'd1);
      check("lv_id", 32'(irq_id[1]), 32'd2);
      cycle(8'h04, 8'h00, 1'b1, 1'b0);
      check("lv_pend", 32'(pending[1]), 32'h04);
      cycle(8'h04, 8'h00, 1'b0, 1'b1);
    end

    // randomized traffic against the model
    do_reset();
    mm = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      rr = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 19) == 0) mm = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle(rr, mm, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: bench did not complete, expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
